// File: rtl/bp_pkg.sv
// Shared types for the branch predictor: RV32I branch funct3 codes,
// the 2-bit BHT counter encoding and the BTB entry layout.
package bp_pkg;

    localparam int BP_XLEN = 32;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    typedef enum logic [1:0] {
        SNT = 2'b00,
        WNT = 2'b01,
        WT  = 2'b10,
        ST  = 2'b11
    } bht_state_t;

    typedef struct packed {
        logic               valid;
        logic [BP_XLEN-1:0] tag;
        logic [BP_XLEN-1:0] target;
        logic               is_jump;
    } btb_entry_t;

    // Saturating 2-bit counter step: the ends (SNT/ST) absorb further moves.
    function automatic bht_state_t bht_next(input bht_state_t state, input logic taken);
        bht_state_t result;
        case (state)
            SNT:     result = taken ? WNT : SNT;
            WNT:     result = taken ? WT  : SNT;
            WT:      result = taken ? ST  : WNT;
            default: result = taken ? ST  : WT;
        endcase
        return result;
    endfunction

endpackage

// File: rtl/branch_resolve.sv
// Execute-stage branch/jump resolution: direction, target, corrected PC
// and mispredict against the prediction made in fetch. Purely combinational.
module branch_resolve
    import bp_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            is_branch,
    input  logic            is_jal,
    input  logic            is_jalr,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] pc,
    input  logic [XLEN-1:0] rs1,
    input  logic [XLEN-1:0] rs2,
    input  logic [XLEN-1:0] imm,
    input  logic            pred_taken,
    input  logic [XLEN-1:0] pred_target,
    output logic            taken,
    output logic [XLEN-1:0] target,
    output logic [XLEN-1:0] correct_pc,
    output logic            mispredict,
    output logic            cond_valid
);

    logic cond;

    // NOTE: every signal driven here gets a default first, so no path leaves it unassigned (no latch).
    always_comb begin
        cond       = 1'b0;
        cond_valid = 1'b1;
        case (funct3)
            F3_BEQ:  cond = (rs1 == rs2);
            F3_BNE:  cond = (rs1 != rs2);
            F3_BLT:  cond = ($signed(rs1) <  $signed(rs2));
            F3_BGE:  cond = ($signed(rs1) >= $signed(rs2));
            F3_BLTU: cond = (rs1 <  rs2);
            F3_BGEU: cond = (rs1 >= rs2);
            default: cond_valid = 1'b0;
        endcase
    end

    always_comb begin
        taken = 1'b0;
        if (is_jal || is_jalr) begin
            taken = 1'b1;
        end else if (is_branch) begin
            taken = cond;
        end

        target     = is_jalr ? ((rs1 + imm) & ~XLEN'(1)) : (pc + imm);
        correct_pc = taken ? target : (pc + XLEN'(4));
        mispredict = (taken != pred_taken) || (taken && (target != pred_target));
    end

endmodule

// File: rtl/branch_predict_unit.sv
// Fetch PC owner with a direct-mapped BTB and 2-bit BHT for prediction;
// resolves execute-stage branches/jumps, redirects on mispredict, counts events.
module branch_predict_unit
    import bp_pkg::*;
#(
    parameter int              XLEN     = 32,
    parameter int              ENTRIES  = 16,
    parameter logic [XLEN-1:0] RESET_PC = {XLEN{1'b0}},
    parameter int              CNT_W    = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             stall,
    output logic [XLEN-1:0]  pc_o,
    output logic             pred_taken_o,
    output logic [XLEN-1:0]  pred_target_o,
    input  logic             ex_valid,
    input  logic             ex_is_branch,
    input  logic             ex_is_jal,
    input  logic             ex_is_jalr,
    input  logic [2:0]       ex_funct3,
    input  logic [XLEN-1:0]  ex_pc,
    input  logic [XLEN-1:0]  ex_rs1,
    input  logic [XLEN-1:0]  ex_rs2,
    input  logic [XLEN-1:0]  ex_imm,
    input  logic             ex_pred_taken,
    input  logic [XLEN-1:0]  ex_pred_target,
    output logic             flush_o,
    output logic [XLEN-1:0]  link_o,
    output logic [CNT_W-1:0] branch_cnt_o,
    output logic [CNT_W-1:0] mispred_cnt_o
);

    localparam int IDX_W = $clog2(ENTRIES);

    btb_entry_t btb [ENTRIES];
    bht_state_t bht [ENTRIES];

    logic [IDX_W-1:0]   fetch_idx;
    logic [BP_XLEN-1:0] fetch_tag;
    btb_entry_t         fetch_entry;
    logic               fetch_hit;

    assign fetch_idx   = pc_o[IDX_W+1:2];
    assign fetch_tag   = BP_XLEN'(pc_o >> (IDX_W + 2));
    assign fetch_entry = btb[fetch_idx];
    assign fetch_hit   = fetch_entry.valid && (fetch_entry.tag == fetch_tag);

    assign pred_taken_o  = fetch_hit && (fetch_entry.is_jump || bht[fetch_idx][1]);
    assign pred_target_o = fetch_hit ? XLEN'(fetch_entry.target) : (pc_o + XLEN'(4));

    logic            res_taken;
    logic [XLEN-1:0] res_target;
    logic [XLEN-1:0] res_correct_pc;
    logic            res_mispredict;
    logic            res_cond_valid;

    branch_resolve #(.XLEN(XLEN)) u_resolve (
        .is_branch   (ex_is_branch),
        .is_jal      (ex_is_jal),
        .is_jalr     (ex_is_jalr),
        .funct3      (ex_funct3),
        .pc          (ex_pc),
        .rs1         (ex_rs1),
        .rs2         (ex_rs2),
        .imm         (ex_imm),
        .pred_taken  (ex_pred_taken),
        .pred_target (ex_pred_target),
        .taken       (res_taken),
        .target      (res_target),
        .correct_pc  (res_correct_pc),
        .mispredict  (res_mispredict),
        .cond_valid  (res_cond_valid)
    );

    logic               resolving;
    logic [IDX_W-1:0]   ex_idx;
    logic [BP_XLEN-1:0] ex_tag;

    assign resolving = ex_valid && (ex_is_branch || ex_is_jal || ex_is_jalr);
    assign ex_idx    = ex_pc[IDX_W+1:2];
    assign ex_tag    = BP_XLEN'(ex_pc >> (IDX_W + 2));
    assign flush_o   = resolving && res_mispredict;
    assign link_o    = ex_pc + XLEN'(4);

    // NOTE: sequential state is written with non-blocking assignments only, so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc_o <= RESET_PC;
        end else if (flush_o) begin
            pc_o <= res_correct_pc;
        end else if (!stall) begin
            pc_o <= pred_target_o;
        end
    end

    // NOTE: only the BTB valid bits and BHT counters are reset; tag/target/is_jump are don't-care until valid.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < ENTRIES; i++) begin
                btb[i].valid <= 1'b0;
                bht[i]       <= WNT;
            end
        end else begin
            if (resolving && ex_is_branch && res_cond_valid) begin
                bht[ex_idx] <= bht_next(bht[ex_idx], res_taken);
            end
            if (resolving && res_taken) begin
                btb[ex_idx] <= '{valid:   1'b1,
                                 tag:     ex_tag,
                                 target:  BP_XLEN'(res_target),
                                 is_jump: ex_is_jal || ex_is_jalr};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            branch_cnt_o  <= '0;
            mispred_cnt_o <= '0;
        end else begin
            if (resolving) branch_cnt_o  <= branch_cnt_o + CNT_W'(1);
            if (flush_o)   mispred_cnt_o <= mispred_cnt_o + CNT_W'(1);
        end
    end

endmodule
